// File: rtl/spi_master_cfg.sv
// spi_master_cfg: single-word SPI master with per-transfer CPOL/CPHA and
// chip-select selection. SCLK, MOSI and CS_N are registered outputs driven
// from the next-state decode, so each phase level is valid from the first
// cycle of that phase.
// Optional feature: define SPI_MASTER_CFG_LSB_FIRST_EN to add the lsb_first_i
// port (per-transfer LSB-first shifting). Without it transfers are MSB-first.
module spi_master_cfg #(
   parameter int DATA_W   = 8,
   parameter int NUM_CS   = 2,
   parameter int HALF_DIV = 50,
   localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic [CS_W-1:0]   cs_idx_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              tx_ready_o,
   output logic              done_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic [NUM_CS-1:0] cs_n_o
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
   ,
   input  logic              lsb_first_i
`endif
);

   localparam int DIV_W = $clog2(HALF_DIV);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(HALF_DIV - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      PH0,
      PH1,
      HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  tx_q, tx_d;
   logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0]  rx_data_q, rx_data_d;
   logic               done_q, done_d;
   logic               cpol_q, cpol_d;
   logic               cpha_q, cpha_d;
   logic [CS_W-1:0]    cs_q, cs_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;
   logic [NUM_CS-1:0]  cs_n_q, cs_n_d;
   logic               lsb_q, lsb_d;
   logic               phase_end;
   logic               accept;

   // Bit k of the word in transmit order (MSB-first unless lsb is set).
   function automatic logic pick_bit(input logic [DATA_W-1:0] w,
                                     input logic [CNT_W-1:0]  k,
                                     input logic              lsb);
      logic [CNT_W-1:0] msb_idx;
      msb_idx = LAST_BIT - k;
      return w[lsb ? k : msb_idx];
   endfunction

   // Received word after shifting in one more MISO bit.
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sh,
                                                  input logic              bit_in,
                                                  input logic              lsb);
      return lsb ? {bit_in, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], bit_in};
   endfunction

   assign phase_end = (div_q == HALF_M1);
   assign accept    = (state_q == IDLE) && start_i;

`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
   // Bit order is captured with the rest of the transfer settings.
   always_comb begin
      lsb_d = accept ? lsb_first_i : lsb_q;
   end

   // Bit-order register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lsb_q <= 1'b0;
      else     lsb_q <= lsb_d;
   end
`else
   assign lsb_d = 1'b0;
   assign lsb_q = 1'b0;
`endif

   // Next-state, counter, shift and output-level decode.
   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      state_d   = state_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      cs_d      = cs_q;
      mosi_d    = mosi_q;

      unique case (state_q)
         IDLE: begin
            // Idle SCLK follows the requested polarity even without a start.
            cpol_d = cpol_i;
            if (start_i) begin
               state_d = PH0;
               div_d   = '0;
               cnt_d   = '0;
               tx_d    = tx_data_i;
               cpha_d  = cpha_i;
               cs_d    = cs_idx_i;
               rx_sh_d = '0;
               mosi_d  = pick_bit(tx_data_i, '0, lsb_d);
            end
         end
         PH0: begin
            if (phase_end) begin
               state_d = PH1;
               div_d   = '0;
               if (!cpha_q) rx_sh_d = shift_in(rx_sh_q, miso_i, lsb_q);
               // Shifting mode (cpha=1) moves MOSI here; cpha=0 already shows it.
               mosi_d  = pick_bit(tx_q, cnt_q, lsb_q);
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         PH1: begin
            if (phase_end) begin
               div_d = '0;
               if (cpha_q) rx_sh_d = shift_in(rx_sh_q, miso_i, lsb_q);
               if (cnt_q == LAST_BIT) begin
                  state_d = HOLD;
               end else begin
                  state_d = PH0;
                  cnt_d   = cnt_q + 1'b1;
                  if (!cpha_q) mosi_d = pick_bit(tx_q, cnt_q + 1'b1, lsb_q);
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         HOLD: begin
            if (phase_end) begin
               state_d   = IDLE;
               div_d     = '0;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Output levels are registered from the next state so they line up
      // with the first cycle of each phase.
      sclk_d = (state_d == PH1) ? ~cpol_d : cpol_d;
      cs_n_d = '1;
      if ((state_d != IDLE) && (int'(cs_d) < NUM_CS)) cs_n_d = ~(NUM_CS'(1) << cs_d);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         div_q     <= '0;
         cnt_q     <= '0;
         tx_q      <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         done_q    <= 1'b0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         cs_q      <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= '1;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         state_q   <= state_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         done_q    <= done_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         cs_q      <= cs_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
      end
   end

   assign rx_data_o  = rx_data_q;
   assign tx_ready_o = (state_q == IDLE);
   assign done_o     = done_q;
   assign sclk_o     = sclk_q;
   assign mosi_o     = mosi_q;
   assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg (DATA_W=8, NUM_CS=2, HALF_DIV=4).
// Stimulus pushes the expected word and done cycle into a scoreboard; a
// monitor pops and compares on every done pulse.
module tb_spi_master_cfg;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] tx_data;
   logic       cpol;
   logic       cpha;
   logic [0:0] cs_idx;
   logic [7:0] rx_data;
   logic       tx_ready;
   logic       done;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic [1:0] cs_n;
   logic       lsb_first;
   logic       loop_en;
   logic       miso_const;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] rx;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   assign miso = loop_en ? mosi : miso_const;

   spi_master_cfg #(.DATA_W(8), .NUM_CS(2), .HALF_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .tx_data_i  (tx_data),
      .cpol_i     (cpol),
      .cpha_i     (cpha),
      .cs_idx_i   (cs_idx),
      .rx_data_o  (rx_data),
      .tx_ready_o (tx_ready),
      .done_o     (done),
      .sclk_o     (sclk),
      .mosi_o     (mosi),
      .miso_i     (miso),
      .cs_n_o     (cs_n)
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
      ,
      .lsb_first_i(lsb_first)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            check("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("rx_data", rx_data, e.rx);
               check("done_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // One complete transfer; records MOSI per bit (at first PH0 and first PH1
   // cycle), SCLK rising edges, MOSI moves off the launch edge, CS_N errors
   // and done pulses. Optionally pulses start during bit 3 with tx_data=0xFF.
   task automatic run_xfer(input logic c_pol, input logic c_pha, input logic [7:0] tx,
                           input logic cs, input logic [7:0] exp_rx, input bit inject,
                           output logic [7:0] ph0w, output logic [7:0] ph1w,
                           output int rises, output int bad_mosi, output int bad_cs,
                           output int dones);
      logic       ps, pm;
      logic [1:0] exp_cs;
      int         p;
      cpol = c_pol;
      cpha = c_pha;
      tick();
      check("sclk_idle_before", sclk, c_pol);
      exp_cs  = cs ? 2'b01 : 2'b10;
      tx_data = tx;
      cs_idx  = cs;
      start   = 1'b1;
      sb.push_back('{exp_rx, cyc + 69});
      ps = sclk; pm = mosi;
      ph0w = '0; ph1w = '0;
      rises = 0; bad_mosi = 0; bad_cs = 0; dones = 0;
      for (int i = 1; i <= 69; i++) begin
         tick();
         if (i == 1) start = 1'b0;
         if (inject && i == 27) begin start = 1'b1; tx_data = 8'hFF; end
         if (inject && i == 28) begin start = 1'b0; tx_data = tx; end
         p = (i - 1) % 8;
         if (i <= 64 && p == 0) ph0w = {ph0w[6:0], mosi};
         if (i <= 64 && p == 4) ph1w = {ph1w[6:0], mosi};
         if (i <= 68 && cs_n !== exp_cs) bad_cs++;
         if (i == 69 && cs_n !== 2'b11) bad_cs++;
         if (!ps && sclk) rises++;
         if (i > 1 && mosi !== pm &&
             !((c_pol == c_pha) ? (ps && !sclk) : (!ps && sclk))) bad_mosi++;
         if (done === 1'b1) dones++;
         ps = sclk; pm = mosi;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] w0, w1;
      int rises, bad_mosi, bad_cs, dones;
      rst = 1'b1; start = 1'b0; tx_data = '0; cpol = 1'b0; cpha = 1'b0;
      cs_idx = '0; lsb_first = 1'b0; loop_en = 1'b1; miso_const = 1'b0;

      // Reset state
      #3;
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_done", done, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_sclk", sclk, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_cs_n", cs_n, 2'b11);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Mode 0, 0xA5 to slave 1, loopback
      run_xfer(1'b0, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, w0, w1, rises, bad_mosi, bad_cs, dones);
      check("m0_mosi_ph0", w0, 8'hA5);
      check("m0_mosi_ph1", w1, 8'hA5);
      check("m0_rises", rises, 8);
      check("m0_mosi_edge", bad_mosi, 0);
      check("m0_cs_n", bad_cs, 0);
      check("m0_dones", dones, 1);
      check("m0_sclk_idle_after", sclk, 1'b0);
      check("m0_tx_ready_done", tx_ready, 1'b1);

      // Mode 3, 0x3C to slave 0, MISO held high
      loop_en = 1'b0; miso_const = 1'b1;
      run_xfer(1'b1, 1'b1, 8'h3C, 1'b0, 8'hFF, 1'b0, w0, w1, rises, bad_mosi, bad_cs, dones);
      check("m3_mosi_ph0", w0, 8'h1E);
      check("m3_mosi_ph1", w1, 8'h3C);
      check("m3_rises", rises, 8);
      check("m3_mosi_edge", bad_mosi, 0);
      check("m3_cs_n", bad_cs, 0);
      check("m3_dones", dones, 1);
      tick();
      check("m3_sclk_idle_after", sclk, 1'b1);
      loop_en = 1'b1;

      // Mode 1, 0x81, start held through the done cycle: back-to-back transfers
      cpol = 1'b0; cpha = 1'b1;
      tick();
      tx_data = 8'h81; cs_idx = 1'b0; start = 1'b1;
      sb.push_back('{8'h81, cyc + 69});
      sb.push_back('{8'h81, cyc + 138});
      dones = 0;
      for (int i = 1; i <= 140; i++) begin
         tick();
         if (done === 1'b1) dones++;
         if (i == 69) check("b2b_ready_in_done", tx_ready, 1'b1);
         if (i == 70) begin
            check("b2b_cs_n_next", cs_n, 2'b10);
            check("b2b_busy_next", tx_ready, 1'b0);
            start = 1'b0;
         end
      end
      check("b2b_dones", dones, 2);

      // Start pulsed during bit 3 must be ignored
      run_xfer(1'b0, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b1, w0, w1, rises, bad_mosi, bad_cs, dones);
      check("ign_mosi_ph0", w0, 8'h5A);
      check("ign_mosi_ph1", w1, 8'h5A);
      check("ign_cs_n", bad_cs, 0);
      check("ign_dones", dones, 1);
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done === 1'b1) dones++;
      end
      check("ign_no_extra_done", dones, 0);

      // Mode 2, reset asserted during bit 4
      cpol = 1'b1; cpha = 1'b0;
      tick(); tick();
      tx_data = 8'hC3; cs_idx = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 33; i++) tick();
      check("abort_busy", tx_ready, 1'b0);
      rst = 1'b1;
      #1;
      check("abort_cs_n", cs_n, 2'b11);
      check("abort_sclk", sclk, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_rx_data", rx_data, 8'h00);
      check("abort_tx_ready", tx_ready, 1'b1);
      tick(); tick();
      rst = 1'b0;
      tick();
      run_xfer(1'b0, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b0, w0, w1, rises, bad_mosi, bad_cs, dones);
      check("post_rst_mosi", w0, 8'h3C);
      check("post_rst_cs_n", bad_cs, 0);
      check("post_rst_dones", dones, 1);

`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
      // LSB-first, 0x01 loopback: first bit on the wire is 1
      lsb_first = 1'b1;
      run_xfer(1'b0, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0, w0, w1, rises, bad_mosi, bad_cs, dones);
      check("lsb_wire_order", w0, 8'h80);
      check("lsb_dones", dones, 1);
      lsb_first = 1'b0;
`endif

      tick(); tick();
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
